// File: rtl/wimax_pkg.sv
// wimax_pkg: shared sizes, amplitude limits and demapper FSM states
package wimax_pkg;
   localparam int IQ_W          = 16;
   localparam int SYM_PER_BLOCK = 96;
   localparam int QPSK_AMP      = 23170;
   localparam int AMP_TOL       = 2048;
   localparam int FIFO_DEPTH    = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BIT_I = 2'd1,
      BIT_Q = 2'd2
   } demap_state_e;

   // True when |x| falls outside the nominal QPSK amplitude window
   function automatic logic amp_bad(input logic [IQ_W-1:0] x);
      logic signed [IQ_W:0] s;
      logic [IQ_W:0] a;
      s = {x[IQ_W-1], x};
      a = x[IQ_W-1] ? $unsigned(-s) : $unsigned(s);
      return (a < (IQ_W+1)'(QPSK_AMP - AMP_TOL)) || (a > (IQ_W+1)'(QPSK_AMP + AMP_TOL));
   endfunction
endpackage

// File: rtl/sym_fifo.sv
// sym_fifo: small synchronous FIFO; push ignored when full, pop ignored when empty
module sym_fifo #(
   parameter int W = 2,
   parameter int D = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push,
   input  logic                 pop,
   input  logic [W-1:0]         wdata,
   output logic [W-1:0]         rdata,
   output logic                 full,
   output logic                 empty,
   output logic [$clog2(D):0]   count
);
   localparam int AW = $clog2(D);
   logic [W-1:0] mem_q [D];
   logic [AW-1:0] wp_q, rp_q;
   logic [AW:0] cnt_q;
   logic do_push, do_pop;
   assign full    = cnt_q == (AW+1)'(D);
   assign empty   = cnt_q == '0;
   assign count   = cnt_q;
   assign rdata   = mem_q[rp_q];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   // storage array is not reset; only pointers define validity
   always_ff @(posedge clk)
      if (do_push) mem_q[wp_q] <= wdata;
   // pointer and occupancy tracking; simultaneous push/pop leaves count unchanged
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wp_q <= (wp_q == AW'(D-1)) ? '0 : wp_q + 1'b1;
         if (do_pop) rp_q <= (rp_q == AW'(D-1)) ? '0 : rp_q + 1'b1;
         cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
endmodule

// File: rtl/qpsk_demapper.sv
// qpsk_demapper: hard-decision QPSK demapper to serial bits; DEMAP_AMP_CHECK_EN adds amplitude flag
module qpsk_demapper
   import wimax_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            Valid_in,
   input  logic [IQ_W-1:0] I_in,
   input  logic [IQ_W-1:0] Q_in,
   output logic            ready_out,
   input  logic            ready_in,
   output logic            dataout,
   output logic            Valid_out,
   output logic            block_done,
   output logic            sym_err
);
`ifdef DEMAP_AMP_CHECK_EN
   localparam int FW = 3;
`else
   localparam int FW = 2;
`endif
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   logic [FW-1:0] wdata, rdata;
   logic full, empty;
   logic [CW-1:0] count;
   logic run_q;
   demap_state_e state_q, state_d;
   logic dout_q, dout_d, vout_q, vout_d, qbit_q, qbit_d, done_q, done_d;
   logic [6:0] sym_q, sym_d;
   logic push, pop, xfer;

   assign ready_out  = run_q && (count < CW'(FIFO_DEPTH));
   assign push       = Valid_in && ready_out && !full;
   assign xfer       = vout_q && ready_in;
   assign pop        = !empty && ((state_q == IDLE) || (state_q == BIT_Q && xfer));
   assign dataout    = dout_q;
   assign Valid_out  = vout_q;
   assign block_done = done_q;

`ifdef DEMAP_AMP_CHECK_EN
   assign wdata = {amp_bad(I_in) || amp_bad(Q_in), I_in[IQ_W-1], Q_in[IQ_W-1]};
`else
   assign wdata = {I_in[IQ_W-1], Q_in[IQ_W-1]};
`endif

   sym_fifo #(.W(FW), .D(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .wdata (wdata),
      .rdata (rdata),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   // output sequencer: pop a symbol, present I-bit then Q-bit, count symbols per block
   always_comb begin
      state_d = state_q;
      dout_d  = dout_q;
      vout_d  = vout_q;
      qbit_d  = qbit_q;
      sym_d   = sym_q;
      done_d  = 1'b0;
      if (pop) begin
         state_d = BIT_I;
         vout_d  = 1'b1;
         dout_d  = rdata[1];
         qbit_d  = rdata[0];
      end else if (state_q == BIT_I && xfer) begin
         state_d = BIT_Q;
         dout_d  = qbit_q;
      end else if (state_q == BIT_Q && xfer) begin
         state_d = IDLE;
         vout_d  = 1'b0;
         dout_d  = 1'b0;
      end
      if (state_q == BIT_Q && xfer) begin
         sym_d  = (sym_q == 7'(SYM_PER_BLOCK-1)) ? 7'd0 : sym_q + 7'd1;
         done_d = sym_q == 7'(SYM_PER_BLOCK-1);
      end
   end

   // state registers; run_q blocks acceptance on the first edge after reset release
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         run_q   <= 1'b0;
         state_q <= IDLE;
         dout_q  <= 1'b0;
         vout_q  <= 1'b0;
         qbit_q  <= 1'b0;
         sym_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         run_q   <= 1'b1;
         state_q <= state_d;
         dout_q  <= dout_d;
         vout_q  <= vout_d;
         qbit_q  <= qbit_d;
         sym_q   <= sym_d;
         done_q  <= done_d;
      end

`ifdef DEMAP_AMP_CHECK_EN
   logic err_q;
   // amplitude flag shown only while the flagged symbol's I-bit is presented
   always_ff @(posedge clk or posedge rst)
      if (rst) err_q <= 1'b0;
      else err_q <= pop ? rdata[2] : (err_q && state_q == BIT_I && !xfer);
   assign sym_err = err_q;
`else
   assign sym_err = 1'b0;
`endif
endmodule

// File: tb/tb_qpsk_demapper.sv
// tb_qpsk_demapper: randomized bench for qpsk_demapper against a bit-queue reference model
module tb_qpsk_demapper;
   logic clk = 1'b0, rst = 1'b1, Valid_in = 1'b0, ready_in = 1'b0;
   logic [15:0] I_in = '0, Q_in = '0;
   logic ready_out, dataout, Valid_out, block_done, sym_err;
   int n_tests = 0, n_fail = 0;
   bit exp_bits[$];
   bit exp_err[$];
   bit exp_done = 0, out_is_q = 0;
   int syms = 0, n_xfer = 0, n_done = 0, n_accept = 0;

   always #5 clk = ~clk;

   qpsk_demapper dut (
      .clk(clk), .rst(rst), .Valid_in(Valid_in), .I_in(I_in), .Q_in(Q_in),
      .ready_out(ready_out), .ready_in(ready_in), .dataout(dataout),
      .Valid_out(Valid_out), .block_done(block_done), .sym_err(sym_err)
   );

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1);
   end

   function automatic bit ref_err(input logic [15:0] i, input logic [15:0] q);
`ifdef DEMAP_AMP_CHECK_EN
      int ai, aq;
      ai = $signed(i);
      aq = $signed(q);
      if (ai < 0) ai = -ai;
      if (aq < 0) aq = -aq;
      return (ai < 23170 - 2048) || (ai > 23170 + 2048) || (aq < 23170 - 2048) || (aq > 23170 + 2048);
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [15:0] rand_sample();
      int v;
      v = 23170 + $urandom_range(0, 6000) - 3000;
      if ($urandom_range(0, 3) == 0) return 16'($urandom);
      return $urandom_range(0, 1) ? 16'(-v) : 16'(v);
   endfunction

   // one clock: drive at negedge, compare outputs against the model, update model for the coming edge
   task automatic step(input bit v, input logic [15:0] i, input logic [15:0] q, input bit r);
      bit e_err;
      @(negedge clk);
      Valid_in = v; I_in = i; Q_in = q; ready_in = r;
      #1;
      n_tests++;
      if (block_done !== exp_done) begin
         n_fail++;
         $display("FAIL block_done: got %b want %b (syms=%0d)", block_done, exp_done, syms);
      end
      if (block_done === 1'b1) n_done++;
      exp_done = 0;
      if (Valid_out === 1'b1) begin
         if (exp_bits.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL spurious_valid: got Valid_out=1 want 0 (no pending bits)");
         end else begin
            n_tests++;
            if (dataout !== exp_bits[0]) begin
               n_fail++;
               $display("FAIL dataout: got %b want %b (%s-bit)", dataout, exp_bits[0], out_is_q ? "Q" : "I");
            end
            e_err = out_is_q ? 1'b0 : exp_err[0];
            n_tests++;
            if (sym_err !== e_err) begin
               n_fail++;
               $display("FAIL sym_err: got %b want %b", sym_err, e_err);
            end
            if (r) begin
               void'(exp_bits.pop_front());
               n_xfer++;
               if (out_is_q) begin
                  void'(exp_err.pop_front());
                  syms++;
                  if (syms == 96) begin exp_done = 1; syms = 0; end
               end
               out_is_q = !out_is_q;
            end
         end
      end else begin
         n_tests++;
         if (sym_err !== 1'b0) begin
            n_fail++;
            $display("FAIL sym_err_idle: got %b want 0", sym_err);
         end
      end
      if (v && ready_out === 1'b1) begin
         exp_bits.push_back(i[15]);
         exp_bits.push_back(q[15]);
         exp_err.push_back(ref_err(i, q));
         n_accept++;
      end
   endtask

   task automatic drain();
      int k;
      k = 0;
      while ((exp_bits.size() != 0 || Valid_out === 1'b1) && k < 60) begin
         step(0, '0, '0, 1);
         k++;
      end
      n_tests++;
      if (exp_bits.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending bits want 0", exp_bits.size());
      end
      step(0, '0, '0, 1);
      step(0, '0, '0, 1);
   endtask

   task automatic test_reset();
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      n_tests += 4;
      if (Valid_out !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", Valid_out); end
      if (dataout !== 1'b0) begin n_fail++; $display("FAIL rst_dataout: got %b want 0", dataout); end
      if (block_done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", block_done); end
      if (sym_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", sym_err); end
      exp_bits.delete(); exp_err.delete();
      exp_done = 0; out_is_q = 0; syms = 0;
      @(negedge clk);
      rst = 1'b0;
      step(0, '0, '0, 1);
      step(0, '0, '0, 1);
      n_tests++;
      if (ready_out !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", ready_out); end
   endtask

   task automatic test_basic(input logic [15:0] i, input logic [15:0] q, input bit b0, input bit b1);
      step(1, i, q, 1);
      step(0, '0, '0, 1);
      n_tests++;
      if (Valid_out !== 1'b0) begin n_fail++; $display("FAIL latency_early: got Valid_out=%b want 0", Valid_out); end
      step(0, '0, '0, 1);
      n_tests++;
      if ({Valid_out, dataout} !== {1'b1, b0}) begin n_fail++; $display("FAIL first_bit: got v=%b d=%b want v=1 d=%b", Valid_out, dataout, b0); end
      step(0, '0, '0, 1);
      n_tests++;
      if ({Valid_out, dataout} !== {1'b1, b1}) begin n_fail++; $display("FAIL second_bit: got v=%b d=%b want v=1 d=%b", Valid_out, dataout, b1); end
      step(0, '0, '0, 1);
      n_tests++;
      if (Valid_out !== 1'b0) begin n_fail++; $display("FAIL after_sym: got Valid_out=%b want 0", Valid_out); end
   endtask

   task automatic test_amp(input logic [15:0] i, input logic [15:0] q, input bit want);
      step(1, i, q, 1);
      step(0, '0, '0, 1);
      step(0, '0, '0, 1);
      n_tests++;
      if ({Valid_out, sym_err} !== {1'b1, want}) begin n_fail++; $display("FAIL amp_flag: got v=%b err=%b want v=1 err=%b", Valid_out, sym_err, want); end
      drain();
   endtask

   task automatic test_stall();
      int acc0;
      acc0 = n_accept;
      for (int c = 0; c < 10; c++) step(1, rand_sample(), rand_sample(), 0);
      n_tests += 2;
      if (n_accept - acc0 != 5) begin n_fail++; $display("FAIL stall_accepts: got %0d want 5", n_accept - acc0); end
      if (ready_out !== 1'b0) begin n_fail++; $display("FAIL stall_ready: got %b want 0", ready_out); end
      drain();
   endtask

   task automatic test_block();
      int x0, d0, gaps;
      bit seen;
      x0 = n_xfer; d0 = n_done; gaps = 0; seen = 0;
      for (int s = 0; s < 96; s++) begin
         for (int h = 0; h < 2; h++) begin
            if (h == 0) step(1, $urandom_range(0, 1) ? 16'hA57E : 16'h5A82, $urandom_range(0, 1) ? 16'hA57E : 16'h5A82, 1);
            else step(0, '0, '0, 1);
            if (Valid_out === 1'b1) seen = 1;
            else if (seen) gaps++;
         end
      end
      drain();
      n_tests += 3;
      if (n_xfer - x0 != 192) begin n_fail++; $display("FAIL block_bits: got %0d want 192", n_xfer - x0); end
      if (n_done - d0 != 1) begin n_fail++; $display("FAIL block_pulses: got %0d want 1", n_done - d0); end
      if (gaps != 0) begin n_fail++; $display("FAIL throughput_gaps: got %0d want 0", gaps); end
   endtask

   task automatic test_reset_mid();
      int d0, x0;
      while (syms < 41 && n_tests < 50000) step(exp_bits.size() < 4, rand_sample(), rand_sample(), 1);
      test_reset();
      d0 = n_done; x0 = n_xfer;
      for (int s = 0; s < 96; s++) begin
         step(1, rand_sample(), rand_sample(), 1);
         step(0, '0, '0, 1);
      end
      drain();
      n_tests += 2;
      if (n_xfer - x0 != 192) begin n_fail++; $display("FAIL mid_bits: got %0d want 192", n_xfer - x0); end
      if (n_done - d0 != 1) begin n_fail++; $display("FAIL mid_pulses: got %0d want 1", n_done - d0); end
   endtask

   task automatic test_random();
      int x0, c;
      x0 = n_xfer; c = 0;
      while (n_xfer - x0 < 500 && c < 5000) begin
         step($urandom_range(0, 1), rand_sample(), rand_sample(), $urandom_range(0, 3) != 0);
         c++;
      end
      drain();
      n_tests++;
      if (n_xfer - x0 < 500) begin n_fail++; $display("FAIL random_progress: got %0d bits want >=500", n_xfer - x0); end
   endtask

   initial begin
      test_reset();
      test_basic(16'h5A82, 16'hA57E, 1'b0, 1'b1);
      test_basic(16'h0000, 16'h8000, 1'b0, 1'b1);
`ifdef DEMAP_AMP_CHECK_EN
      test_amp(16'h1000, 16'h5A82, 1'b1);
`else
      test_amp(16'h1000, 16'h5A82, 1'b0);
`endif
      test_amp(16'h5A82, 16'h5A82, 1'b0);
      test_stall();
      test_reset();
      test_block();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
